// File: rtl/perip_timecmp_pkg.sv
// perip_timecmp_pkg
//   Shared definitions for the timer-compare peripheral: bus width, register
//   offsets (word index taken from addr[3:2]), CTRL bit positions, the compare
//   reset value and the FSM state encoding.
package perip_timecmp_pkg;

   localparam int DATA_W = 32;

   // Register word offsets, decoded from addr[3:2]
   localparam logic [1:0] TIMECMP_CMP_LO = 2'd0;
   localparam logic [1:0] TIMECMP_CMP_HI = 2'd1;
   localparam logic [1:0] TIMECMP_CTRL   = 2'd2;
   localparam logic [1:0] TIMECMP_PERIOD = 2'd3;

   // CTRL bit positions
   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_PENDING  = 2;
   localparam int CTRL_OVERRUN  = 3;
   localparam int CTRL_IE       = 4;

   // All ones: only matched when time_us is all ones, so it effectively never fires
   localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_FIRED    = 2'd2
   } timecmp_state_t;

endpackage

// File: rtl/timecmp_ge64.sv
// timecmp_ge64
//   Unsigned 64-bit greater-or-equal comparator. Kept as its own block so a
//   pipeline stage can be inserted later without touching the register file.
//   Ports:
//     a_i  : left operand (current time)
//     b_i  : right operand (compare value)
//     ge_o : 1 when a_i >= b_i (unsigned)
module timecmp_ge64 (
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   output logic        ge_o
);

   assign ge_o = (a_i >= b_i);

endmodule

// File: rtl/perip_timecmp.sv
// perip_timecmp
//   Memory-mapped timer compare / timer interrupt. Holds a 64-bit compare
//   value and raises a registered level interrupt when time_us >= compare.
//   One-shot and periodic (auto-reload) modes; compare is updated tear-free
//   by writing LO (which disarms) and then HI (which re-arms if EN).
//   Bus: single-cycle, no handshake. A write commits on the clk edge where
//   ena && rw; reads are combinational from addr and never stall.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     ena, rw  : bus select, 1 = write / 0 = read
//     addr     : byte offset, addr[3:2] selects the register
//     rdata    : read data (combinational)
//     wdata    : write data
//     time_us  : free-running microsecond time
//     irq      : timer interrupt level
//     state_o  : FSM state, for observation
module perip_timecmp
   import perip_timecmp_pkg::*;
#(
   parameter int PERIOD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              rw,
   input  logic [DATA_W-1:0] addr,
   output logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] wdata,
   input  logic [63:0]       time_us,
   output logic              irq,
   output timecmp_state_t    state_o
);

   timecmp_state_t      state_q, state_d;
   logic [63:0]         cmp_q, cmp_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                en_q, en_d;
   logic                periodic_q, periodic_d;
   logic                ie_q, ie_d;
   logic                pending_q, pending_d;
   logic                overrun_q, overrun_d;
   logic                irq_q, irq_d;

   logic       ge;
   logic       hit;
   logic       reload;
   logic       wr_lo, wr_hi, wr_ctrl, wr_period, wr_cmp;
   logic [1:0] sel;
   logic       unused_addr_bits;

   assign sel              = addr[3:2];
   assign unused_addr_bits = ^{addr[DATA_W-1:4], addr[1:0]};

   assign wr_lo     = ena && rw && (sel == TIMECMP_CMP_LO);
   assign wr_hi     = ena && rw && (sel == TIMECMP_CMP_HI);
   assign wr_ctrl   = ena && rw && (sel == TIMECMP_CTRL);
   assign wr_period = ena && rw && (sel == TIMECMP_PERIOD);
   assign wr_cmp    = wr_lo || wr_hi;

   timecmp_ge64 u_ge (
      .a_i  (time_us),
      .b_i  (cmp_q),
      .ge_o (ge)
   );

   assign hit    = (state_q == ST_ARMED) && ge;
   // Periodic reload uses the pre-write PERIODIC/PERIOD values
   assign reload = hit && periodic_q && (period_q != '0);

   always_comb begin
      state_d    = state_q;
      cmp_d      = cmp_q;
      period_d   = period_q;
      en_d       = en_q;
      periodic_d = periodic_q;
      ie_d       = ie_q;

      // A compare write in the same cycle as a hit suppresses the hit's flags.
      // A W1C loses to a simultaneous set.
      pending_d = (pending_q & ~(wr_ctrl & wdata[CTRL_PENDING]))
                | (hit & ~wr_cmp);
      overrun_d = (overrun_q & ~(wr_ctrl & wdata[CTRL_OVERRUN]))
                | (reload & pending_q & ~wr_cmp);

      if (reload) begin
         cmp_d = cmp_q + 64'(period_q);
      end else if (hit) begin
         state_d = ST_FIRED;
      end

      if (wr_lo) begin
         cmp_d   = {cmp_q[63:32], wdata};
         state_d = ST_DISARMED;
      end

      if (wr_hi) begin
         cmp_d   = {wdata, cmp_q[31:0]};
         state_d = en_q ? ST_ARMED : ST_DISARMED;
      end

      if (wr_ctrl) begin
         en_d       = wdata[CTRL_EN];
         periodic_d = wdata[CTRL_PERIODIC];
         ie_d       = wdata[CTRL_IE];
         if (!wdata[CTRL_EN]) begin
            state_d = ST_DISARMED;
         end else if (!en_q) begin
            state_d = ST_ARMED;
         end
      end

      if (wr_period) begin
         period_d = PERIOD_W'(wdata);
      end

      irq_d = pending_d & ie_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_DISARMED;
         cmp_q      <= CMP_RESET;
         period_q   <= '0;
         en_q       <= 1'b0;
         periodic_q <= 1'b0;
         ie_q       <= 1'b0;
         pending_q  <= 1'b0;
         overrun_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmp_q      <= cmp_d;
         period_q   <= period_d;
         en_q       <= en_d;
         periodic_q <= periodic_d;
         ie_q       <= ie_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         irq_q      <= irq_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         TIMECMP_CMP_LO: rdata = cmp_q[31:0];
         TIMECMP_CMP_HI: rdata = cmp_q[63:32];
         TIMECMP_CTRL: begin
            rdata[CTRL_EN]       = en_q;
            rdata[CTRL_PERIODIC] = periodic_q;
            rdata[CTRL_PENDING]  = pending_q;
            rdata[CTRL_OVERRUN]  = overrun_q;
            rdata[CTRL_IE]       = ie_q;
         end
         default: rdata = DATA_W'(period_q);
      endcase
   end

   assign irq     = irq_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_perip_timecmp.sv
// tb_perip_timecmp
//   Directed and randomized checks of perip_timecmp against a rule-level
//   reference model kept in this file.
module tb_perip_timecmp;
   import perip_timecmp_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic           ena;
   logic           rw;
   logic [31:0]    addr;
   logic [31:0]    rdata;
   logic [31:0]    wdata;
   logic [63:0]    time_us;
   logic           irq;
   timecmp_state_t state_o;

   int checks = 0;
   int errors = 0;

   // Reference model: architectural register contents plus "armed"/"fired"
   logic [63:0] m_cmp;
   logic [31:0] m_period;
   bit m_en, m_per, m_ie, m_pend, m_ovr, m_armed, m_fired, m_irq;

   perip_timecmp #(.PERIOD_W(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .rw      (rw),
      .addr    (addr),
      .rdata   (rdata),
      .wdata   (wdata),
      .time_us (time_us),
      .irq     (irq),
      .state_o (state_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_period = 0;
      m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_ovr = 0;
      m_armed = 0; m_fired = 0; m_irq = 0;
   endtask

   function automatic logic [31:0] model_rdata(input logic [1:0] r);
      case (r)
         2'd0:    return m_cmp[31:0];
         2'd1:    return m_cmp[63:32];
         2'd2:    return {27'b0, m_ie, m_ovr, m_pend, m_per, m_en};
         default: return m_period;
      endcase
   endfunction

   function automatic logic [1:0] model_state();
      if (m_armed) return 2'd1;
      if (m_fired) return 2'd2;
      return 2'd0;
   endfunction

   // Advance the model by one clock using the inputs present this cycle
   task automatic model_step();
      bit hit, reload;
      logic [63:0] n_cmp;
      logic [31:0] n_period;
      bit n_en, n_per, n_ie, n_pend, n_ovr, n_armed, n_fired;
      n_cmp = m_cmp; n_period = m_period;
      n_en = m_en; n_per = m_per; n_ie = m_ie; n_pend = m_pend; n_ovr = m_ovr;
      n_armed = m_armed; n_fired = m_fired;

      hit    = m_armed && (time_us >= m_cmp);
      reload = hit && m_per && (m_period != 0);
      if (hit) begin
         n_pend = 1;
         if (reload) begin
            n_cmp = m_cmp + {32'b0, m_period};
            if (m_pend) n_ovr = 1;
         end else begin
            n_armed = 0;
            n_fired = 1;
         end
      end

      if (ena && rw) begin
         case (addr[3:2])
            2'd0: begin
               n_cmp = {m_cmp[63:32], wdata};
               n_pend = m_pend; n_ovr = m_ovr;
               n_armed = 0; n_fired = 0;
            end
            2'd1: begin
               n_cmp = {wdata, m_cmp[31:0]};
               n_pend = m_pend; n_ovr = m_ovr;
               n_armed = m_en; n_fired = 0;
            end
            2'd2: begin
               n_en = wdata[0]; n_per = wdata[1]; n_ie = wdata[4];
               if (wdata[2] && !hit) n_pend = 0;
               if (wdata[3] && !(reload && m_pend)) n_ovr = 0;
               if (!wdata[0]) begin
                  n_armed = 0; n_fired = 0;
               end else if (!m_en) begin
                  n_armed = 1; n_fired = 0;
               end
            end
            default: n_period = wdata;
         endcase
      end

      m_cmp = n_cmp; m_period = n_period;
      m_en = n_en; m_per = n_per; m_ie = n_ie; m_pend = n_pend; m_ovr = n_ovr;
      m_armed = n_armed; m_fired = n_fired;
      m_irq = n_pend && n_ie;
   endtask

   // ---------------- drivers ----------------
   // One clock: model advances, DUT samples, outputs compared 1 time unit later
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("irq", irq, m_irq);
      check("state", state_o, model_state());
      ena = 0;
      rw  = 0;
   endtask

   task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
      ena   = 1;
      rw    = 1;
      addr  = {28'b0, r, 2'b00};
      wdata = d;
      tick();
   endtask

   task automatic rd_model(input string tag, input logic [1:0] r);
      addr = {28'b0, r, 2'b00};
      #1;
      check(tag, rdata, model_rdata(r));
   endtask

   task automatic rd_const(input string tag, input logic [1:0] r, input logic [31:0] exp);
      addr = {28'b0, r, 2'b00};
      #1;
      check(tag, rdata, exp);
   endtask

   // ---------------- sequence ----------------
   initial begin
      int exp_hits[$];
      int got_hits[$];
      logic [1:0] rr;
      logic [31:0] rd;

      rst = 1; ena = 0; rw = 0; addr = 0; wdata = 0; time_us = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // Reset state
      check("rst_irq", irq, 0);
      check("rst_state", state_o, ST_DISARMED);
      rd_const("rst_cmp_lo", TIMECMP_CMP_LO, 32'hFFFF_FFFF);
      rd_const("rst_cmp_hi", TIMECMP_CMP_HI, 32'hFFFF_FFFF);
      rd_const("rst_ctrl", TIMECMP_CTRL, 32'h0);
      rd_const("rst_period", TIMECMP_PERIOD, 32'h0);

      // One-shot
      time_us = 95;
      bus_wr(TIMECMP_PERIOD, 0);
      bus_wr(TIMECMP_CMP_LO, 100);
      bus_wr(TIMECMP_CMP_HI, 0);
      bus_wr(TIMECMP_CTRL, 32'h11);
      for (int t = 95; t <= 105; t++) begin
         time_us = 64'(t);
         tick();
         check("os_irq_ramp", irq, (t >= 100) ? 1 : 0);
      end
      rd_const("os_ctrl", TIMECMP_CTRL, 32'h15);
      check("os_state", state_o, ST_FIRED);
      tick();
      check("os_irq_hold", irq, 1);
      bus_wr(TIMECMP_CTRL, 32'h15);
      check("os_irq_w1c", irq, 0);

      // Periodic
      time_us = 45;
      bus_wr(TIMECMP_CTRL, 32'h00);
      bus_wr(TIMECMP_PERIOD, 10);
      bus_wr(TIMECMP_CMP_LO, 50);
      bus_wr(TIMECMP_CMP_HI, 0);
      bus_wr(TIMECMP_CTRL, 32'h13);
      exp_hits = '{50, 60, 70, 80};
      for (int t = 45; t <= 80; t++) begin
         time_us = 64'(t);
         tick();
         if (irq) begin
            got_hits.push_back(t);
            bus_wr(TIMECMP_CTRL, 32'h17);
         end
      end
      check("per_hit_count", got_hits.size(), exp_hits.size());
      for (int i = 0; i < exp_hits.size() && i < got_hits.size(); i++)
         check("per_hit_time", got_hits[i], exp_hits[i]);
      rd_const("per_cmp_lo", TIMECMP_CMP_LO, 90);
      rd_const("per_ctrl", TIMECMP_CTRL, 32'h13);

      // Tear-free update
      time_us = 5;
      bus_wr(TIMECMP_CTRL, 32'h04);
      bus_wr(TIMECMP_CMP_LO, 0);
      bus_wr(TIMECMP_CMP_HI, 1);
      bus_wr(TIMECMP_CTRL, 32'h11);
      check("tf_armed", state_o, ST_ARMED);
      bus_wr(TIMECMP_CMP_LO, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("tf_hold_state", state_o, ST_DISARMED);
         check("tf_hold_irq", irq, 0);
      end
      bus_wr(TIMECMP_CMP_HI, 2);
      check("tf_rearmed", state_o, ST_ARMED);
      tick();
      tick();
      check("tf_no_hit", irq, 0);
      rd_const("tf_cmp_hi", TIMECMP_CMP_HI, 2);

      // Catch-up / overrun
      bus_wr(TIMECMP_CTRL, 32'h0C);
      bus_wr(TIMECMP_PERIOD, 1);
      bus_wr(TIMECMP_CMP_LO, 10);
      bus_wr(TIMECMP_CMP_HI, 0);
      time_us = 20;
      bus_wr(TIMECMP_CTRL, 32'h13);
      for (int i = 0; i < 14; i++) begin
         tick();
         rd_const("cu_cmp_lo", TIMECMP_CMP_LO, (11 + i > 21) ? 21 : 11 + i);
      end
      rd_const("cu_ctrl", TIMECMP_CTRL, 32'h1F);
      check("cu_state", state_o, ST_ARMED);

      // Simultaneous W1C and periodic hit
      time_us = 21;
      bus_wr(TIMECMP_CTRL, 32'h17);
      rd_const("sim_ctrl", TIMECMP_CTRL, 32'h1F);
      check("sim_irq", irq, 1);
      rd_const("sim_cmp_lo", TIMECMP_CMP_LO, 22);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         time_us = time_us + 64'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            5: bus_wr(TIMECMP_CMP_LO, time_us[31:0] + $urandom_range(0, 20));
            6: bus_wr(TIMECMP_CMP_HI, ($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
            7: bus_wr(TIMECMP_CTRL, $urandom_range(0, 31));
            8: bus_wr(TIMECMP_PERIOD, $urandom_range(0, 6));
            9: bus_wr(TIMECMP_CTRL, 32'h13 | ($urandom_range(0, 3) << 2));
            default: tick();
         endcase
         rd = $urandom;
         rr = rd[1:0];
         rd_model("rnd_rdata", rr);
      end

      // Async reset with irq high
      time_us = 30;
      bus_wr(TIMECMP_CTRL, 32'h0C);
      bus_wr(TIMECMP_PERIOD, 0);
      bus_wr(TIMECMP_CMP_LO, 0);
      bus_wr(TIMECMP_CMP_HI, 0);
      bus_wr(TIMECMP_CTRL, 32'h11);
      tick();
      check("ar_irq_before", irq, 1);
      #2 rst = 1;
      model_reset();
      #1;
      check("ar_irq_now", irq, 0);
      rd_const("ar_cmp_lo", TIMECMP_CMP_LO, 32'hFFFF_FFFF);
      rd_const("ar_cmp_hi", TIMECMP_CMP_HI, 32'hFFFF_FFFF);
      rd_const("ar_ctrl", TIMECMP_CTRL, 32'h0);
      check("ar_state", state_o, ST_DISARMED);
      @(negedge clk);
      rst = 0;
      @(posedge clk);
      #1;
      tick();
      tick();
      check("ar_irq_after", irq, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/perip_timecmp.md
Name: perip_timecmp

Overview:
- Memory-mapped timer-compare / timer-interrupt peripheral, directly downstream of the 64-bit microsecond time counter peripheral.
- Consumes the 64-bit time_us value, holds a 64-bit compare value, and raises a level timer interrupt to the CPU when time_us >= compare.
- Supports one-shot and periodic (auto-reload) modes and a tear-free lo/hi compare update sequence.

Parameters:
- PERIOD_W, 32, width of the periodic reload register; zero-extended to 64 bits when added.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high (already decided)
- ena  in  1  bus select for this peripheral
- rw  in  1  1 = write, 0 = read
- addr  in  `DATA_BUS  byte offset within the peripheral; only addr[3:2] decoded
- rdata  out  `DATA_BUS  read data, combinational from addr
- wdata  in  `DATA_BUS  write data
- time_us  in  64  current time in microseconds, from the time counter
- irq  out  1  timer interrupt, registered level

Behaviour:
- Register map, decoded by addr[3:2]:
  - 0 CMP_LO: RW.
  - 1 CMP_HI: RW.
  - 2 CTRL: bit0 EN, bit1 PERIODIC, bit4 IE are RW; bit2 PENDING and bit3 OVERRUN are read / write-1-to-clear; other bits read 0.
  - 3 PERIOD: RW, PERIOD_W bits.
- Writes commit on the rising clk edge when ena && rw. Reads are combinational; rdata = 0 for undecoded bits.
- Reset values: cmp = 64'hFFFF_FFFF_FFFF_FFFF, PERIOD = 0, CTRL = 0, state = DISARMED, irq = 0.
- FSM states:
  - DISARMED: no comparison.
  - ARMED: each cycle evaluate hit = (time_us >= cmp), unsigned 64-bit.
  - FIRED: one-shot match taken; no further comparison.
- FSM transitions:
  - Write CMP_LO (any state) -> DISARMED.
  - Write CMP_HI: -> ARMED if EN (after the write) = 1, else DISARMED. Software order for a tear-free update is LO then HI.
  - Write CTRL with EN = 0 -> DISARMED. EN 0 -> 1 with no CMP write in the same cycle -> ARMED.
  - ARMED && hit && (!PERIODIC || PERIOD == 0) -> FIRED; set PENDING.
  - ARMED && hit && PERIODIC && PERIOD != 0: cmp <= cmp + PERIOD (64-bit, wraps modulo 2^64); set PENDING; remain ARMED. If PENDING was already 1, also set OVERRUN.
  - FIRED -> ARMED only via a CMP_HI write or an EN 0 -> 1 rewrite.
- irq: registered, irq <= PENDING_next & IE. Asserts exactly 1 clk after the cycle in which hit is evaluated true.
- Latency: hit is evaluated on the time_us value present in cycle N; PENDING = 1 and irq = 1 are visible in cycle N+1.
- Simultaneous events:
  - A W1C of PENDING in the same cycle as a new hit: the hit wins, PENDING stays 1.
  - A CMP_LO/CMP_HI write in the same cycle as a hit: the write wins, no PENDING set, cmp takes wdata.
  - A CTRL write that changes PERIODIC in the same cycle as a hit: the new value applies from the next cycle; the hit uses the old value.
- Periodic catch-up: if cmp + PERIOD is still <= time_us, hit recurs on the next cycle and OVERRUN is set. No lost reloads; one reload per cycle.
- Wrap-around: cmp = 64'hFFFF...FFFF is only reachable when time_us is all ones (reset default: effectively never fires). Periodic add overflow wraps silently.
- Asynchronous reset mid-operation returns all state to reset values; irq drops immediately.

Decomposition:
- Shared package/common include:
  - Register offset constants TIMECMP_CMP_LO = 0, TIMECMP_CMP_HI = 1, TIMECMP_CTRL = 2, TIMECMP_PERIOD = 3.
  - CTRL bit-index constants.
  - FSM state encodings (2-bit: DISARMED = 0, ARMED = 1, FIRED = 2).
- Optional sub-module: timecmp_ge64, a 64-bit unsigned >= comparator (kept separate so it can be pipelined later). The register file and FSM stay in perip_timecmp.

Test Plan:
- One-shot:
  - Stimulus: reset; write PERIOD = 0, CMP_LO = 100, CMP_HI = 0, CTRL = 0x11; ramp time_us 95..105.
  - Required: irq rises exactly 1 clk after time_us = 100; CTRL reads 0x15; irq stays high after 105; writing CTRL = 0x15 (W1C) drops irq the next cycle.
- Periodic:
  - Stimulus: PERIOD = 10, CMP = 50, CTRL = 0x13; ramp time_us 45..80, clearing PENDING after each hit.
  - Required: hits at 50, 60, 70, 80; CMP reads 90 at the end; OVERRUN = 0.
- Tear-free update:
  - Stimulus: armed with CMP = 0x1_0000_0000; time_us = 0x5; write CMP_LO = 0 and hold 3 cycles before writing CMP_HI = 2.
  - Required: no irq during the hold (DISARMED); afterwards ARMED, no hit.
- Catch-up / overrun:
  - Stimulus: PERIODIC, PERIOD = 1, CMP = 10, time_us held at 20.
  - Required: PENDING and OVERRUN set; CMP increments by 1 per cycle until it reaches 21, then hits stop.
- Simultaneous clear and hit:
  - Stimulus: PENDING = 1; W1C write to CTRL in the same cycle periodic hit is true.
  - Required: PENDING still 1 and irq stays 1.
- Async reset:
  - Stimulus: assert rst mid-cycle while irq = 1.
  - Required: irq = 0 immediately; CMP reads 0xFFFFFFFF/0xFFFFFFFF; CTRL = 0.
